// File: rtl/uart_baud_gen_frac.sv
// rtl/uart_baud_gen_frac.sv - fractional baud/oversample tick generator
//
// Generates single-cycle tick enables on SysClk for the UART TX/RX paths.
// The prescaler period P is the active integer divisor. When BAUD_FRAC_EN is
// defined, a fractional accumulator also adds one clock every time it
// overflows. A new divisor is loaded into a shadow register and becomes active
// on a tick boundary, so a divisor change never produces a short or glitched
// period.
//
// Optional feature macro: BAUD_FRAC_EN (fractional accumulator present)
//
// Ports:
//   SysClk    in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   en        in   count enable; 0 freezes all counters and suppresses ticks
//   restart   in   synchronous phase restart back to a bit start
//   div_int   in   integer divisor to load (values below 2 are clamped to 2)
//   div_frac  in   fractional divisor to load (ignored without BAUD_FRAC_EN)
//   div_load  in   single-cycle load request, accepted while div_busy=0
//   div_busy  out  shadow divisor captured but not yet active
//   os_tick   out  oversample tick, one cycle wide
//   mid_tick  out  mid-bit sample tick, coincident with os_tick
//   bit_tick  out  bit-boundary tick, coincident with os_tick
//   os_cnt    out  current oversample phase

module uart_baud_gen_frac #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int DIV_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OSR      = 16,
    parameter int DEF_INT  = 325,
    parameter int DEF_FRAC = 8
) (
    input  logic                    SysClk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    restart,
    input  logic [DIV_W-1:0]        div_int,
    input  logic [FRAC_W-1:0]       div_frac,
    input  logic                    div_load,
    output logic                    div_busy,
    output logic                    os_tick,
    output logic                    mid_tick,
    output logic                    bit_tick,
    output logic [$clog2(OSR)-1:0]  os_cnt
);

    localparam int               OSW     = $clog2(OSR);
    localparam logic [OSW-1:0]   MID_PH  = OSW'(OSR / 2 - 1);
    localparam logic [OSW-1:0]   BIT_PH  = OSW'(OSR - 1);
    localparam logic [DIV_W-1:0] MIN_INT = DIV_W'(2);
    localparam logic [DIV_W:0]   ONE_P   = (DIV_W + 1)'(1);

    logic [DIV_W-1:0] act_int;
    logic [DIV_W-1:0] shd_int;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W:0]   period;
    logic [DIV_W:0]   last;
    logic             wrap;
    logic             load_ok;
    logic             apply;

    // CLK_FREQ only documents the clock the defaults were derived for.
    logic unused_cfg;
    assign unused_cfg = (CLK_FREQ != 0);

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] act_frac;
    logic [FRAC_W-1:0] shd_frac;
    logic [FRAC_W-1:0] acc;
    logic              carry;

    // One extra clock in the period following every accumulator overflow.
    assign period = {1'b0, act_int} + {{DIV_W{1'b0}}, carry};
`else
    // Fractional input kept only for pin compatibility.
    logic unused_frac;
    assign unused_frac = (^div_frac) ^ (DEF_FRAC != 0);

    assign period = {1'b0, act_int};
`endif

    assign last    = period - ONE_P;
    assign wrap    = en && ({1'b0, cnt} == last);
    assign load_ok = div_load && !div_busy;
    // A pending shadow goes live on a tick boundary, at a restart, or at
    // once while frozen (no boundary would ever arrive with en low).
    assign apply   = div_busy && (restart || wrap || !en);

    always_ff @(posedge SysClk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            os_cnt   <= '0;
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
            div_busy <= 1'b0;
            act_int  <= DIV_W'(DEF_INT);
            shd_int  <= '0;
`ifdef BAUD_FRAC_EN
            act_frac <= FRAC_W'(DEF_FRAC);
            shd_frac <= '0;
            acc      <= '0;
            carry    <= 1'b0;
`endif
        end else begin
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;

            if (restart) begin
                cnt    <= '0;
                os_cnt <= '0;
`ifdef BAUD_FRAC_EN
                acc    <= '0;
                carry  <= 1'b0;
`endif
            end else if (en) begin
                if (wrap) begin
                    cnt      <= '0;
                    os_tick  <= 1'b1;
                    // Phase decode uses the value before the increment.
                    mid_tick <= (os_cnt == MID_PH);
                    bit_tick <= (os_cnt == BIT_PH);
                    os_cnt   <= os_cnt + 1'b1;
`ifdef BAUD_FRAC_EN
                    {carry, acc} <= {1'b0, acc} + {1'b0, act_frac};
`endif
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            // apply needs div_busy=1 and load_ok needs div_busy=0, so at most
            // one of these runs; a later clear of acc/carry overrides the
            // fractional update above.
            if (apply) begin
                act_int  <= shd_int;
                div_busy <= 1'b0;
`ifdef BAUD_FRAC_EN
                act_frac <= shd_frac;
                acc      <= '0;
                carry    <= 1'b0;
`endif
            end else if (load_ok) begin
                shd_int  <= (div_int < MIN_INT) ? MIN_INT : div_int;
                div_busy <= 1'b1;
`ifdef BAUD_FRAC_EN
                shd_frac <= div_frac;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb/tb_uart_baud_gen_frac.sv - scoreboard testbench for uart_baud_gen_frac

module tb_uart_baud_gen_frac;

`ifdef BAUD_FRAC_EN
    localparam int FRAC_ON = 1;
`else
    localparam int FRAC_ON = 0;
`endif

    logic        SysClk   = 1'b0;
    logic        rst      = 1'b1;
    logic        en       = 1'b0;
    logic        restart  = 1'b0;
    logic        div_load = 1'b0;
    logic [15:0] div_int  = '0;
    logic [3:0]  div_frac = '0;
    logic        div_busy;
    logic        os_tick;
    logic        mid_tick;
    logic        bit_tick;
    logic [3:0]  os_cnt;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Expected divisor state and tick phase
    int exp_int  = 325;
    int exp_frac = 8;
    int exp_k    = 0;
    int exp_oc   = 0;

    typedef struct {
        int cyc;
        bit mid;
        bit bt;
    } exp_t;

    exp_t sb[$];

    uart_baud_gen_frac #(
        .CLK_FREQ (50_000_000),
        .DIV_W    (16),
        .FRAC_W   (4),
        .OSR      (16),
        .DEF_INT  (325),
        .DEF_FRAC (8)
    ) dut (
        .SysClk   (SysClk),
        .rst      (rst),
        .en       (en),
        .restart  (restart),
        .div_int  (div_int),
        .div_frac (div_frac),
        .div_load (div_load),
        .div_busy (div_busy),
        .os_tick  (os_tick),
        .mid_tick (mid_tick),
        .bit_tick (bit_tick),
        .os_cnt   (os_cnt)
    );

    always #5 SysClk = ~SysClk;

    always @(posedge SysClk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge SysClk);
    endtask

    task automatic step_to(input int t);
        while (cyc < t) @(negedge SysClk);
    endtask

    // Carry out of the fractional accumulator after wrap j (acc starts at 0).
    function automatic int carry_at(input int j, input int f);
        if (j == 0 || FRAC_ON == 0) return 0;
        return (((j * f) / 16) != (((j - 1) * f) / 16)) ? 1 : 0;
    endfunction

    task automatic next_period(output int p);
        p = exp_int + carry_at(exp_k, exp_frac);
        exp_k++;
    endtask

    task automatic push(input int t);
        exp_t e;
        e.cyc = t;
        e.mid = (exp_oc == 7);
        e.bt  = (exp_oc == 15);
        sb.push_back(e);
        exp_oc = (exp_oc + 1) % 16;
    endtask

    task automatic drained();
        #1;
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    // Enable, expect n ticks, then freeze right after the last one (cnt=0).
    task automatic run_ticks(input int n);
        int t;
        int p;
        t  = cyc;
        en = 1'b1;
        for (int i = 0; i < n; i++) begin
            next_period(p);
            t += p;
            push(t);
        end
        step_to(t);
        en = 1'b0;
        drained();
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge SysClk);
            if (!rst) begin
                if (os_tick) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_os_tick: got tick at cycle %0d expected none", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("os_tick_cycle", cyc, e.cyc);
                        chk("mid_tick", int'(mid_tick), int'(e.mid));
                        chk("bit_tick", int'(bit_tick), int'(e.bt));
                    end
                end else if (mid_tick || bit_tick) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_phase_tick: got mid=%0d bit=%0d expected 0 without os_tick (cycle %0d)",
                             mid_tick, bit_tick, cyc);
                end
            end
        end
    endtask

    initial begin
        int c;
        int t1;
        int t2;
        int p;

        fork
            monitor();
        join_none
        fork
            begin
                repeat (60000) @(posedge SysClk);
                $display("FAIL watchdog: got no completion within 60000 cycles");
                $fatal(1, "timeout");
            end
        join_none

        // Reset state
        step(3);
        chk("reset_os_tick", int'(os_tick), 0);
        chk("reset_mid_tick", int'(mid_tick), 0);
        chk("reset_bit_tick", int'(bit_tick), 0);
        chk("reset_div_busy", int'(div_busy), 0);
        chk("reset_os_cnt", int'(os_cnt), 0);
        rst = 1'b0;

        // Defaults: 325-clock ticks, bit every 5200, mid 2600 after bit
        run_ticks(24);

        // 115200 baud divisor 27 + 2/16, loaded while frozen
        div_int  = 16'd27;
        div_frac = 4'd2;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        chk("t2_busy_after_load", int'(div_busy), 1);
        step(1);
        chk("t2_busy_applied_frozen", int'(div_busy), 0);
        exp_int  = 27;
        exp_frac = 2;
        exp_k    = 0;
        run_ticks(24);

        // Load while running; second load during busy is ignored
        c  = cyc;
        en = 1'b1;
        next_period(p);
        t1 = c + p;
        push(t1);
        step_to(c + 3);
        div_int  = 16'd40;
        div_frac = 4'd0;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        chk("t3_busy_after_load", int'(div_busy), 1);
        step_to(c + 6);
        div_int  = 16'd99;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        chk("t3_busy_second_load", int'(div_busy), 1);
        step_to(t1 - 1);
        chk("t3_busy_before_boundary", int'(div_busy), 1);
        step_to(t1);
        chk("t3_busy_cleared_boundary", int'(div_busy), 0);
        exp_int  = 40;
        exp_frac = 0;
        exp_k    = 0;
        next_period(p);
        t2 = t1 + p;
        push(t2);
        next_period(p);
        t2 += p;
        push(t2);
        step_to(t2);
        en = 1'b0;
        drained();

        // Restart mid-count at os_cnt=9
        p = (9 - exp_oc + 16) % 16;
        if (p != 0) run_ticks(p);
        chk("t4_os_cnt_before_restart", int'(os_cnt), 9);
        c  = cyc;
        en = 1'b1;
        step_to(c + 10);
        restart = 1'b1;
        step_to(c + 13);
        chk("t4_os_cnt_in_restart", int'(os_cnt), 0);
        restart = 1'b0;
        exp_oc  = 0;
        exp_k   = 0;
        run_ticks(16);

        // div_int=0 clamps to 2; en=0 freezes phase
        div_int  = 16'd0;
        div_frac = 4'd0;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        chk("t5_busy_after_load", int'(div_busy), 1);
        step(1);
        chk("t5_busy_applied", int'(div_busy), 0);
        exp_int  = 2;
        exp_frac = 0;
        exp_k    = 0;
        run_ticks(5);
        step(1);
        chk("t5_os_cnt_frozen_start", int'(os_cnt), exp_oc);
        step(50);
        chk("t5_os_cnt_frozen_end", int'(os_cnt), exp_oc);
        run_ticks(3);

        // Async reset mid-bit with a load pending
        div_int  = 16'd100;
        div_frac = 4'd0;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        step(1);
        chk("t6_busy_applied", int'(div_busy), 0);
        exp_int = 100;
        exp_k   = 0;
        c  = cyc;
        en = 1'b1;
        next_period(p);
        t1 = c + p;
        push(t1);
        step_to(t1 + 20);
        div_int  = 16'd60;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        chk("t6_busy_pending", int'(div_busy), 1);
        step_to(t1 + 30);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_os_tick", int'(os_tick), 0);
        chk("t6_rst_mid_tick", int'(mid_tick), 0);
        chk("t6_rst_bit_tick", int'(bit_tick), 0);
        chk("t6_rst_div_busy", int'(div_busy), 0);
        chk("t6_rst_os_cnt", int'(os_cnt), 0);
        step(2);
        rst      = 1'b0;
        exp_int  = 325;
        exp_frac = 8;
        exp_k    = 0;
        exp_oc   = 0;
        run_ticks(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
